wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Writeback stage directly upstream of the 8-bit, 16-entry register file; it is the only driver of the register file's write port (data, write enable, write address).
- Merges single-cycle ALU results with multi-cycle data-memory load returns, and buffers loads that lose arbitration.
- Supplies same-cycle forwarding and busy flags to the operand-read logic, so readers never see a stale register.

Parameters:
- pw, 4, register address width (2**pw registers).
- DW, 8, data width.
- DEPTH, 2, load buffer depth (entries, ≥1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; always accepted, no back-pressure.
- alu_addr  in  pw  ALU destination register.
- alu_dat  in  DW  ALU result.
- ld_valid  in  1  load return present.
- ld_ready  out  1  stage can accept a load this cycle.
- ld_addr  in  pw  load destination register.
- ld_dat  in  DW  load data.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  pw  register file write address (registered).
- wr_dat  out  DW  register file write data (registered; drives reg file dat_in).
- rd_addrA, rd_addrB  in  pw  current operand read addresses.
- fwdA_hit, fwdB_hit  out  1  forward wr_dat instead of the reg file read.
- fwdA_dat, fwdB_dat  out  DW  forwarded data.
- busyA, busyB  out  1  operand register has a buffered, unwritten load; consumer must stall.

Behaviour:
- Reset (clk edge with reset=1):
  - wr_en=0, wr_addr=0, wr_dat=0.
  - Buffer emptied.
  - ld_ready=0 while reset is high.
  - Loads presented during reset are dropped.
- ld_ready = !reset && (buffer count < DEPTH). Combinational and independent of ld_valid.
- A load is accepted when ld_valid && ld_ready. While ld_ready=0, the producer holds ld_* stable.
- Output register selection each cycle, in priority order:
  1. alu_valid=1: wr_en<=1, wr_addr<=alu_addr, wr_dat<=alu_dat. An accepted load is pushed to the buffer tail.
  2. Else buffer non-empty: pop head into the output register, wr_en<=1. An accepted load is pushed to the tail in the same cycle; this is legal even at count==DEPTH-1.
  3. Else buffer empty and load accepted: bypass straight into the output register, wr_en<=1. Latency is 1 cycle, and the buffer is not written.
  4. Else wr_en<=0. wr_addr and wr_dat hold their values.
- Latency:
  - ALU result: 1 cycle to wr_en.
  - Buffered load: 1 cycle after it reaches the head and no ALU result is present.
- Ordering:
  - Loads are written in acceptance order (FIFO).
  - ALU results are never delayed.
- Full buffer: ld_ready=0. There is no pass-through even if a pop occurs in the same cycle.
- Starvation is permitted: continuous alu_valid blocks load drain indefinitely.
- Forwarding:
  - fwdX_hit = wr_en && (wr_addr == rd_addrX); fwdX_dat = wr_dat. Both are combinational.
  - This covers the cycle before the reg file write lands.
- Busy:
  - busyX = OR over valid buffer entries of (entry.addr == rd_addrX). Combinational.
  - The output register is excluded; it is covered by forwarding.
- Same address in buffer twice: both entries are written in order, and the last write wins in the reg file.
- ALU write to an address that is busy is a producer protocol violation. The stage still writes both, ALU first, then the load later. The bench flags it as an assertion.
- Buffer pointers wrap modulo DEPTH. The count is width $clog2(DEPTH+1).

Decomposition:
- Package wb_pkg:
  - Constants DW and PW.
  - typedef struct packed {logic[PW-1:0] addr; logic[DW-1:0] dat;} wb_req_t.
- Sub-module wb_fifo:
  - Parameterised synchronous FIFO of wb_req_t.
  - Ports: push, pop, full, empty, head, count, and a flattened entries/valid vector for the busy compare.
  - Synchronous active-high reset.
- The arbiter holds the priority mux, output register, and forward/busy compare logic.

Test Plan:
- Reset: assert reset with ld_valid=1 → wr_en=0, ld_ready=0 during reset. After release, ld_ready=1 and the buffer is empty.
- ALU only: alu_valid, addr 3, dat 0x5A → next cycle wr_en=1, wr_addr=3, wr_dat=0x5A. With rd_addrA=3, fwdA_hit=1 and fwdA_dat=0x5A.
- Load bypass: idle, then ld_valid with addr 7, dat 0xC3 → next cycle wr_en=1, wr_addr=7. busyA is never set for rd_addrA=7.
- Contention:
  - Stimulus: alu (2, 0x11) and load (5, 0x22) in the same cycle, then idle.
  - Writes: cycle+1 writes 2/0x11, cycle+2 writes 5/0x22.
  - Busy: busyB=1 for rd_addrB=5 during cycle+1 only.
- Full: alu_valid held 3 cycles while loads (1, 0xA1), (4, 0xA4), (6, 0xA6) are offered → first two accepted; ld_ready=0 for the third until the first pop. Writes follow in the order 1, 4, 6.
- Duplicate address: two buffered loads to reg 9 (0x01 then 0x02) → written in order. The final reg file value is 0x02, and busy stays high until the second entry leaves the buffer.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared constants and the buffered load request type for the writeback stage.
package wb_pkg;
    localparam int DW    = 8;
    localparam int PW    = 4;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [DW-1:0] dat;
    } wb_req_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU and load producers, register file write port, operand forwarding.
// Handshake: a load transfers on a rising clk edge where ld_valid && ld_ready; ld_ready
// never depends on ld_valid, and the producer holds ld_* stable while ld_ready is low.
// ALU results have no handshake and are always taken.
interface wb_arbiter_if;
    import wb_pkg::*;

    logic             alu_valid;
    logic [PW-1:0]    alu_addr;
    logic [DW-1:0]    alu_dat;
    logic             ld_valid;
    logic             ld_ready;
    logic [PW-1:0]    ld_addr;
    logic [DW-1:0]    ld_dat;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [DW-1:0]    wr_dat;
    logic [PW-1:0]    rd_addrA;
    logic [PW-1:0]    rd_addrB;
    logic             fwdA_hit;
    logic             fwdB_hit;
    logic [DW-1:0]    fwdA_dat;
    logic [DW-1:0]    fwdB_dat;
    logic             busyA;
    logic             busyB;
    logic [CNT_W-1:0] buf_count;

    modport slave (
        input  alu_valid, alu_addr, alu_dat, ld_valid, ld_addr, ld_dat, rd_addrA, rd_addrB,
        output ld_ready, wr_en, wr_addr, wr_dat, fwdA_hit, fwdB_hit, fwdA_dat, fwdB_dat,
               busyA, busyB, buf_count
    );

    modport master (
        output alu_valid, alu_addr, alu_dat, ld_valid, ld_addr, ld_dat, rd_addrA, rd_addrB,
        input  ld_ready, wr_en, wr_addr, wr_dat, fwdA_hit, fwdB_hit, fwdA_dat, fwdB_dat,
               busyA, busyB, buf_count
    );
endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of load requests; exposes every slot and its valid bit for busy compares.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int FDEPTH = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push_i,
    input  wb_req_t                             push_data_i,
    input  logic                                pop_i,
    output logic                                full_o,
    output logic                                empty_o,
    output wb_req_t                             head_o,
    output logic [$clog2(FDEPTH+1)-1:0]         count_o,
    output logic [FDEPTH*$bits(wb_req_t)-1:0]   entries_o,
    output logic [FDEPTH-1:0]                   valid_o
);
    localparam int PTR_W = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam int FC_W  = $clog2(FDEPTH + 1);
    localparam int RW    = $bits(wb_req_t);

    wb_req_t           mem_q [FDEPTH];
    logic [FDEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [FC_W-1:0]   count_q, count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d          = ptr_inc(wr_ptr_q);
            valid_d[wr_ptr_q] = 1'b1;
        end
        // Pop clears its slot after push set; they never collide since push and pop
        // together imply the buffer is neither empty nor full.
        if (pop_i) begin
            rd_ptr_d          = ptr_inc(rd_ptr_q);
            valid_d[rd_ptr_q] = 1'b0;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push_i) mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    for (genvar i = 0; i < FDEPTH; i++) begin : g_flat
        assign entries_o[i*RW +: RW] = mem_q[i];
    end

    assign valid_o = valid_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == FC_W'(FDEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win, buffered loads drain in order, idle loads bypass.
module wb_arbiter
    import wb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);
    localparam int RW = $bits(wb_req_t);

    logic                  push, pop, full, empty, ld_acc;
    wb_req_t               head, ld_req;
    logic [DEPTH*RW-1:0]   entries;
    logic [DEPTH-1:0]      valid;
    logic [CNT_W-1:0]      count;

    logic                  wr_en_q, wr_en_d;
    logic [PW-1:0]         wr_addr_q, wr_addr_d;
    logic [DW-1:0]         wr_dat_q, wr_dat_d;
    logic                  busy_a, busy_b;

    assign ld_req = '{addr: bus.ld_addr, dat: bus.ld_dat};
    assign bus.ld_ready = !reset && !full;
    assign ld_acc = bus.ld_valid && bus.ld_ready;

    wb_fifo #(.FDEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_data_i(ld_req),
        .pop_i      (pop),
        .full_o     (full),
        .empty_o    (empty),
        .head_o     (head),
        .count_o    (count),
        .entries_o  (entries),
        .valid_o    (valid)
    );

    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;
        if (bus.alu_valid) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.alu_addr;
            wr_dat_d  = bus.alu_dat;
            push      = ld_acc;
        end else if (!empty) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head.addr;
            wr_dat_d  = head.dat;
            pop       = 1'b1;
            push      = ld_acc;
        end else if (ld_acc) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.ld_addr;
            wr_dat_d  = bus.ld_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    // Busy covers only buffered loads; the output register is handled by forwarding.
    always_comb begin
        wb_req_t e;
        busy_a = 1'b0;
        busy_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            e = wb_req_t'(entries[i*RW +: RW]);
            if (valid[i] && (e.addr == bus.rd_addrA)) busy_a = 1'b1;
            if (valid[i] && (e.addr == bus.rd_addrB)) busy_b = 1'b1;
        end
    end

    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_dat    = wr_dat_q;
    assign bus.fwdA_hit  = wr_en_q && (wr_addr_q == bus.rd_addrA);
    assign bus.fwdB_hit  = wr_en_q && (wr_addr_q == bus.rd_addrB);
    assign bus.fwdA_dat  = wr_dat_q;
    assign bus.fwdB_dat  = wr_dat_q;
    assign bus.busyA     = busy_a;
    assign bus.busyB     = busy_b;
    assign bus.buf_count = count;
endmodule
